// File: rtl/dmux_dispatch.sv
`timescale 1ns/1ps
// Credit-controlled feeder for the fixed-latency pipelined demultiplexer: registers sel/in, emits a latency-matched out_valid.
// Define DMUX_DISPATCH_STATS_EN to build the accepted/dropped beat counters; otherwise stat_* are tied to 0.
module dmux_dispatch #(
    parameter int WIDTH        = 8,
    parameter int OUTPUT_COUNT = 4,
    parameter int LATENCY      = 2,
    parameter int CREDITS      = 4,
    localparam int SELECT_SIZE = $clog2(OUTPUT_COUNT),
    localparam int CW          = $clog2(CREDITS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [SELECT_SIZE-1:0]     s_dest,
    input  logic [WIDTH-1:0]           s_data,
    output logic [SELECT_SIZE-1:0]     dmux_sel,
    output logic [WIDTH-1:0]           dmux_in,
    output logic [OUTPUT_COUNT-1:0]    out_valid,
    input  logic [OUTPUT_COUNT-1:0]    credit_return,
    output logic [OUTPUT_COUNT*CW-1:0] credit_level,
    output logic [1:0]                 err,
    output logic [31:0]                stat_accept,
    output logic [31:0]                stat_drop
);

    localparam logic [SELECT_SIZE:0] OUT_LIMIT  = (SELECT_SIZE + 1)'(OUTPUT_COUNT);
    localparam logic [CW-1:0]        CREDIT_MAX = CW'(CREDITS);
    localparam logic [CW-1:0]        CREDIT_ONE = CW'(1);

    logic [CW-1:0]           credit     [OUTPUT_COUNT];
    logic [OUTPUT_COUNT-1:0] token_pipe [LATENCY+1];

    logic                    dest_legal;
    logic                    dest_has_credit;
    logic                    accept;
    logic                    accept_legal;
    logic                    accept_drop;
    logic [OUTPUT_COUNT-1:0] dest_onehot;
    logic [OUTPUT_COUNT-1:0] take;
    logic [OUTPUT_COUNT-1:0] credit_full;
    logic [OUTPUT_COUNT-1:0] overflow;

    assign dest_legal = {1'b0, s_dest} < OUT_LIMIT;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        dest_has_credit = 1'b0;
        dest_onehot     = '0;
        credit_full     = '0;
        for (int i = 0; i < OUTPUT_COUNT; i++) begin
            credit_full[i] = (credit[i] == CREDIT_MAX);
            if (s_dest == SELECT_SIZE'(i)) begin
                dest_onehot[i]  = 1'b1;
                dest_has_credit = (credit[i] != '0);
            end
        end
    end

    // Illegal destinations are always accepted so a bad beat can never wedge the stream.
    assign s_ready      = !dest_legal || dest_has_credit;
    assign accept       = s_valid && s_ready;
    assign accept_legal = accept && dest_legal;
    assign accept_drop  = accept && !dest_legal;
    assign take         = dest_onehot & {OUTPUT_COUNT{accept_legal}};
    assign overflow     = credit_return & ~take & credit_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: array elements are reset individually; counters and tokens must be known after reset.
            for (int i = 0; i < OUTPUT_COUNT; i++) credit[i] <= CREDIT_MAX;
        end else begin
            for (int i = 0; i < OUTPUT_COUNT; i++) begin
                unique case ({take[i], credit_return[i]})
                    2'b10:   credit[i] <= credit[i] - CREDIT_ONE;
                    2'b01:   if (!credit_full[i]) credit[i] <= credit[i] + CREDIT_ONE;
                    default: ;
                endcase
            end
        end
    end

    // Stage 0 loads with sel/in, so stage LATENCY lines up with the demux output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= LATENCY; j++) token_pipe[j] <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take its neighbour's pre-edge value.
            token_pipe[0] <= take;
            for (int j = 1; j <= LATENCY; j++) token_pipe[j] <= token_pipe[j-1];
        end
    end

    assign out_valid = token_pipe[LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmux_sel <= '0;
            dmux_in  <= '0;
            err      <= '0;
        end else begin
            if (accept_legal) begin
                dmux_sel <= s_dest;
                dmux_in  <= s_data;
            end
            err <= err | {|overflow, accept_drop};
        end
    end

    always_comb begin
        credit_level = '0;
        for (int i = 0; i < OUTPUT_COUNT; i++) credit_level[i*CW +: CW] = credit[i];
    end

`ifdef DMUX_DISPATCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accept <= '0;
            stat_drop   <= '0;
        end else begin
            if (accept_legal) stat_accept <= stat_accept + 32'd1;
            if (accept_drop)  stat_drop   <= stat_drop + 32'd1;
        end
    end
`else
    assign stat_accept = '0;
    assign stat_drop   = '0;
`endif

endmodule

// File: tb/tb_dmux_dispatch.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for dmux_dispatch: a queue-based model predicts strobes, credits and flags;
// a second instance (3 outputs, LATENCY=0) covers illegal destinations and the zero-latency alignment.
module tb_dmux_dispatch;

    localparam int N    = 4;
    localparam int LAT  = 2;
    localparam int CRED = 4;
    localparam int CW   = 3;
    localparam int BN   = 3;
    localparam int BCW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          s_valid, s_ready;
    logic [1:0]    s_dest, dmux_sel;
    logic [7:0]    s_data, dmux_in;
    logic [N-1:0]  out_valid, credit_return;
    logic [N*CW-1:0] credit_level;
    logic [1:0]    err;
    logic [31:0]   stat_accept, stat_drop;

    logic          b_s_valid, b_s_ready;
    logic [1:0]    b_s_dest, b_dmux_sel;
    logic [7:0]    b_s_data, b_dmux_in;
    logic [BN-1:0] b_out_valid, b_credit_return;
    logic [BN*BCW-1:0] b_credit_level;
    logic [1:0]    b_err;
    logic [31:0]   b_stat_accept, b_stat_drop;

    dmux_dispatch #(.WIDTH(8), .OUTPUT_COUNT(N), .LATENCY(LAT), .CREDITS(CRED)) u_dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_dest(s_dest),
        .s_data(s_data), .dmux_sel(dmux_sel), .dmux_in(dmux_in), .out_valid(out_valid),
        .credit_return(credit_return), .credit_level(credit_level), .err(err),
        .stat_accept(stat_accept), .stat_drop(stat_drop)
    );

    dmux_dispatch #(.WIDTH(8), .OUTPUT_COUNT(BN), .LATENCY(0), .CREDITS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_dest(b_s_dest),
        .s_data(b_s_data), .dmux_sel(b_dmux_sel), .dmux_in(b_dmux_in), .out_valid(b_out_valid),
        .credit_return(b_credit_return), .credit_level(b_credit_level), .err(b_err),
        .stat_accept(b_stat_accept), .stat_drop(b_stat_drop)
    );

    // Reference model: credits, flags and the expected strobe schedule.
    typedef struct {
        int dest;
        int due;
    } exp_t;

    exp_t        sb[$];
    int          cred [N];
    logic [1:0]  m_err;
    logic [1:0]  m_sel;
    logic [7:0]  m_data;
    int unsigned m_acc;
    int          ecnt = 0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, ecnt);
    endtask

    function automatic bit m_ready(input logic [1:0] d);
        return cred[d] != 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) cred[i] = CRED;
        m_err  = '0;
        m_sel  = '0;
        m_data = '0;
        m_acc  = 0;
        sb.delete();
    endtask

    // Apply the effect of the edge that just passed.
    task automatic commit(input bit acc, input logic [1:0] d, input logic [7:0] x, input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            bit dec;
            dec = acc && (int'(d) == i);
            if (dec && !r[i]) cred[i]--;
            else if (!dec && r[i]) begin
                if (cred[i] == CRED) m_err[1] = 1'b1;
                else cred[i]++;
            end
        end
        if (acc) begin
            m_sel  = d;
            m_data = x;
            m_acc++;
            sb.push_back('{int'(d), ecnt + LAT});
        end
    endtask

    // Drive one cycle of stimulus; called just after a rising edge.
    task automatic step(input logic v, input logic [1:0] d, input logic [7:0] x, input logic [N-1:0] r);
        bit acc;
        s_valid = v;
        s_dest = d;
        s_data = x;
        credit_return = r;
        #1;
        check("s_ready", 32'(s_ready), 32'(m_ready(d)));
        acc = v && m_ready(d);
        @(posedge clk);
        #1;
        commit(acc, d, x, r);
    endtask

    task automatic do_reset();
        logic [N*CW-1:0] full_cl;
        rst_n = 1'b0;
        s_valid = 1'b0; s_dest = '0; s_data = '0; credit_return = '0;
        b_s_valid = 1'b0; b_s_dest = '0; b_s_data = '0; b_credit_return = '0;
        model_reset();
        for (int i = 0; i < N; i++) full_cl[i*CW +: CW] = CW'(CRED);
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_credit_level", 32'(credit_level), 32'(full_cl));
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
    endtask

    initial forever @(posedge clk) ecnt++;

    // Monitor: compares every cycle against the model, popping strobes as they fall due.
    logic [N-1:0]    exp_ov;
    logic [N*CW-1:0] exp_cl;
    always @(negedge clk) begin
        if (mon_en) begin
            exp_ov = '0;
            if (sb.size() > 0 && sb[0].due == ecnt) begin
                exp_ov = N'(1 << sb[0].dest);
                void'(sb.pop_front());
            end
            for (int i = 0; i < N; i++) exp_cl[i*CW +: CW] = CW'(cred[i]);
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            check("credit_level", 32'(credit_level), 32'(exp_cl));
            check("err", 32'(err), 32'(m_err));
            check("dmux_sel", 32'(dmux_sel), 32'(m_sel));
            check("dmux_in", 32'(dmux_in), 32'(m_data));
`ifdef DMUX_DISPATCH_STATS_EN
            check("stat_accept", stat_accept, m_acc);
`else
            check("stat_accept", stat_accept, 32'd0);
`endif
            check("stat_drop", stat_drop, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] r;
        rst_n = 1'b0;
        mon_en = 1'b1;
        do_reset();

        // Single beat to dest 2; strobe due LAT cycles after sel/in update.
        step(1'b1, 2'd2, 8'hA5, '0);
        repeat (4) step(1'b0, 2'd0, 8'h00, '0);

        // Exhaust dest 1, then refill one credit while the fifth beat waits.
        for (int i = 0; i < 5; i++) step(1'b1, 2'd1, 8'(8'h10 + i), '0);
        step(1'b1, 2'd1, 8'h14, 4'b0010);
        step(1'b1, 2'd1, 8'h14, '0);

        // Simultaneous accept and return on dest 3 at credit 2.
        step(1'b1, 2'd3, 8'h31, '0);
        step(1'b1, 2'd3, 8'h32, '0);
        step(1'b1, 2'd3, 8'h33, 4'b1000);

        // Return on a full counter saturates and flags overflow.
        step(1'b0, 2'd0, 8'h00, 4'b0001);
        check("err_overflow", 32'(err), 32'h2);
        repeat (LAT + 1) step(1'b0, 2'd0, 8'h00, '0);

        do_reset();
        for (int it = 0; it < 1500; it++) begin
            if (it == 400) begin
                step(1'b1, 2'd0, 8'h5A, '0);
                do_reset();
            end
            if (it == 900) begin
                step(1'b1, 2'd3, 8'hC3, '0);
                step(1'b0, 2'd0, 8'h00, '0);
                do_reset();
            end
            for (int i = 0; i < N; i++)
                r[i] = (cred[i] < CRED) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom), r);
        end
        repeat (LAT + 2) step(1'b0, 2'd0, 8'h00, '0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        do_reset();

        // Zero-latency instance: strobe coincides with dmux_in; illegal dest is swallowed.
        b_s_valid = 1'b1; b_s_dest = 2'd2; b_s_data = 8'h3C;
        #1;
        check("b_s_ready_legal", 32'(b_s_ready), 32'd1);
        @(posedge clk);
        #1;
        check("b_out_valid_lat0", 32'(b_out_valid), 32'b100);
        check("b_dmux_sel", 32'(b_dmux_sel), 32'd2);
        check("b_dmux_in", 32'(b_dmux_in), 32'h3C);
        b_s_dest = 2'd3; b_s_data = 8'hFF;
        #1;
        check("b_s_ready_illegal", 32'(b_s_ready), 32'd1);
        @(posedge clk);
        #1;
        b_s_valid = 1'b0;
        check("b_out_valid_illegal", 32'(b_out_valid), 32'd0);
        check("b_dmux_sel_hold", 32'(b_dmux_sel), 32'd2);
        check("b_dmux_in_hold", 32'(b_dmux_in), 32'h3C);
        check("b_err_illegal", 32'(b_err), 32'h1);
        check("b_credit_level", 32'(b_credit_level), 32'({2'd1, 2'd2, 2'd2}));
`ifdef DMUX_DISPATCH_STATS_EN
        check("b_stat_accept", b_stat_accept, 32'd1);
        check("b_stat_drop", b_stat_drop, 32'd1);
`else
        check("b_stat_accept", b_stat_accept, 32'd0);
        check("b_stat_drop", b_stat_drop, 32'd0);
`endif
        @(posedge clk);
        #1;
        check("b_out_valid_idle", 32'(b_out_valid), 32'd0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
